// File: rtl/axi_log_pkg.sv
// Shared types and constants for the log drain controller.
package axi_log_pkg;

    localparam int unsigned WORDS_PER_ENTRY = 3;
    localparam int unsigned BRAM_RD_LAT     = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_WAIT_CLR = 3'd4
    } drain_state_e;

endpackage

// File: rtl/log_drain_buf.sv
// Two-entry fall-through FIFO between BRAM read data and the output stream.
module log_drain_buf #(
    parameter int unsigned W = 33
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop, store, pop_mem;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_o  = (count_q != 2'd0) || push_i;
        data_o   = (count_q != 2'd0) ? mem_q[rd_ptr_q] : (push_i ? data_i : '0);
        pop      = valid_o && ready_i;
        // An arriving word that is accepted while the buffer is empty bypasses storage.
        store    = push_i && !((count_q == 2'd0) && pop);
        pop_mem  = pop && (count_q != 2'd0);
        if (store) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_mem) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, store} - {1'b0, pop_mem};
        count_o = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_log_drain_ctrl.sv
// Drains the event logger BRAM into a word stream, then clears the logger and
// waits for its full flag to settle before reporting done.
module axi_log_drain_ctrl #(
    parameter int unsigned NUM_LOG_ENTRIES = 16384,
    parameter int unsigned WORDS_PER_ENTRY = axi_log_pkg::WORDS_PER_ENTRY
) (
    input  logic        Clk_CI,
    input  logic        Rst_RBI,
    input  logic        Start_SI,
    input  logic        AutoDrain_SI,
    input  logic [15:0] NumEntries_DI,
    input  logic        Full_SI,
    output logic        Clear_SO,
    output logic        BramEn_SO,
    output logic [31:0] BramAddr_DO,
    output logic [3:0]  BramWrEn_SO,
    input  logic [31:0] BramRdData_DI,
    output logic        OutValid_SO,
    input  logic        OutReady_SI,
    output logic [31:0] OutData_DO,
    output logic        OutLast_SO,
    output logic        Busy_SO,
    output logic        Done_SO,
    output logic [2:0]  State_DO
);
    import axi_log_pkg::*;

    localparam logic [17:0] MAX_WORDS = 18'(NUM_LOG_ENTRIES * WORDS_PER_ENTRY);

    drain_state_e state_q, state_d;
    logic [17:0]  word_total_q, word_total_d;
    logic [17:0]  rd_idx_q, rd_idx_d;
    logic         rd_vld_q, rd_vld_d;
    logic         rd_last_q, rd_last_d;
    logic         low_seen_q, low_seen_d;
    logic         full_q;

    logic         trigger, issue, is_last_rd, accept;
    logic [17:0]  req_words;
    logic [1:0]   buf_count, occ;
    logic         buf_valid;
    logic [32:0]  buf_data;

    // Output stream: a word transfers in any cycle with OutValid_SO and OutReady_SI
    // both high; once raised, valid, data and last hold until that transfer.
    log_drain_buf #(.W(33)) u_buf (
        .clk_i   (Clk_CI),
        .rst_ni  (Rst_RBI),
        .push_i  (rd_vld_q),
        .data_i  ({rd_last_q, BramRdData_DI}),
        .ready_i (OutReady_SI),
        .valid_o (buf_valid),
        .data_o  (buf_data),
        .count_o (buf_count)
    );

    always_comb begin
        state_d      = state_q;
        word_total_d = word_total_q;
        rd_idx_d     = rd_idx_q;
        low_seen_d   = low_seen_q;
        issue        = 1'b0;
        Clear_SO     = 1'b0;
        Done_SO      = 1'b0;
        trigger      = Start_SI || (AutoDrain_SI && Full_SI && !full_q);
        req_words    = 18'(NumEntries_DI) * 18'(WORDS_PER_ENTRY);
        occ          = buf_count + {1'b0, rd_vld_q};
        is_last_rd   = (rd_idx_q == word_total_q - 18'd1);
        accept       = buf_valid && OutReady_SI;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    rd_idx_d     = 18'd0;
                    word_total_d = (req_words > MAX_WORDS) ? MAX_WORDS : req_words;
                    state_d      = (req_words == 18'd0) ? ST_CLEAR : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Never let stored words plus the in-flight read exceed the buffer depth.
                issue = (occ < 2'd2);
                if (issue) begin
                    rd_idx_d = rd_idx_q + 18'd1;
                    if (is_last_rd) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (accept && buf_data[32]) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                Clear_SO   = 1'b1;
                low_seen_d = 1'b0;
                state_d    = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                low_seen_d = !Full_SI;
                if (!Full_SI && low_seen_q) begin
                    Done_SO = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rd_vld_d    = issue;
        rd_last_d   = issue && is_last_rd;
        BramEn_SO   = issue;
        BramAddr_DO = issue ? {12'd0, rd_idx_q, 2'b00} : 32'd0;
        BramWrEn_SO = 4'd0;
        OutValid_SO = buf_valid;
        OutData_DO  = buf_data[31:0];
        OutLast_SO  = buf_data[32];
        Busy_SO     = (state_q != ST_IDLE);
        State_DO    = state_q;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q      <= ST_IDLE;
            word_total_q <= 18'd0;
            rd_idx_q     <= 18'd0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            low_seen_q   <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_total_q <= word_total_d;
            rd_idx_q     <= rd_idx_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            low_seen_q   <= low_seen_d;
            full_q       <= Full_SI;
        end
    end

endmodule

// File: tb/tb_axi_log_drain_ctrl.sv
// Scoreboard bench for axi_log_drain_ctrl: directed drains, monitor checks the stream.
module tb_axi_log_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_drain = 1'b0;
    logic        full = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] num_entries = 16'd0;
    logic        clear, bram_en, out_valid, out_last, busy, done;
    logic [31:0] bram_addr, bram_rd_data, out_data;
    logic [3:0]  bram_wr_en;
    logic [2:0]  state_dbg;

    logic [32:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          bram_cnt, clear_cnt, done_cnt, viol_cnt, issued, accepted;
    int          first_valid_cyc, clear_cyc, done_cyc, start_cyc, drop_cyc;
    logic [31:0] last_addr, first_addr;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [32:0] prev_word = 33'd0;

    axi_log_drain_ctrl dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .Start_SI      (start),
        .AutoDrain_SI  (auto_drain),
        .NumEntries_DI (num_entries),
        .Full_SI       (full),
        .Clear_SO      (clear),
        .BramEn_SO     (bram_en),
        .BramAddr_DO   (bram_addr),
        .BramWrEn_SO   (bram_wr_en),
        .BramRdData_DI (bram_rd_data),
        .OutValid_SO   (out_valid),
        .OutReady_SI   (out_ready),
        .OutData_DO    (out_data),
        .OutLast_SO    (out_last),
        .Busy_SO       (busy),
        .Done_SO       (done),
        .State_DO      (state_dbg)
    );

    // ---------------- clock / reset / BRAM model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_fn(input logic [31:0] idx);
        return (idx * 32'h0001_0001) ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) bram_rd_data <= bram_en ? word_fn(bram_addr >> 2) : 32'hDEAD_BEEF;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input int words);
        for (int i = 0; i < words; i++) begin
            exp_q.push_back({(i == words - 1), word_fn(32'(i))});
        end
    endtask

    task automatic reset_counters();
        bram_cnt = 0; clear_cnt = 0; done_cnt = 0; viol_cnt = 0;
        issued = 0; accepted = 0;
        first_valid_cyc = -1; clear_cyc = -1; done_cyc = -1; drop_cyc = -1;
        last_addr = '1; first_addr = '1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {out_valid, out_last, bram_en, clear, done, busy, bram_wr_en, state_dbg}, 64'd0);
        check({name, "_data"}, out_data, 64'd0);
        check({name, "_addr"}, bram_addr, 64'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && !prev_ready) begin
                check("hold_stable", {out_valid, out_last, out_data}, {1'b1, prev_word});
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bram_en) begin
                if (issued - accepted >= 2) viol_cnt++;
                if (bram_cnt == 0) first_addr = bram_addr;
                bram_cnt++;
                last_addr = bram_addr;
            end
            if (clear) begin clear_cnt++; clear_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", {out_last, out_data});
                end else begin
                    check("stream_word", {out_last, out_data}, exp_q.pop_front());
                end
                accepted++;
            end
            if (bram_en) issued++;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_word  = {out_last, out_data};
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic run_drain(input bit use_start, input bit raise_full, input bit toggle,
                             input bit extra_starts, input int release_delay, input int budget);
        int n = 0;
        int hold = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 0) begin
                start_cyc = cyc;
                if (use_start) start = 1'b1;
                if (raise_full) full = 1'b1;
            end
            if (extra_starts && (n == 5 || (clear_cnt != 0 && hold == 1))) start = 1'b1;
            out_ready = toggle ? ~out_ready : 1'b1;
            if (clear_cnt != 0 && full) begin
                if (hold == release_delay) begin
                    full = 1'b0;
                    drop_cyc = cyc;
                end
                hold++;
            end
            n++;
        end
        repeat (20) begin
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_counters();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 2 entries, always ready, logger full until after clear
        reset_counters();
        num_entries = 16'd2;
        full = 1'b1;
        push_expected(6);
        run_drain(1'b1, 1'b0, 1'b0, 1'b0, 3, 200);
        check("t1_bram_reads", bram_cnt, 6);
        check("t1_last_addr", last_addr, 32'h14);
        check("t1_first_valid_lat", first_valid_cyc - start_cyc, 2);
        check("t1_clear_pulses", clear_cnt, 1);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_done_after_low", done_cyc - drop_cyc, 1);
        check("t1_queue_left", exp_q.size(), 0);

        // 4 entries, ready toggling
        reset_counters();
        num_entries = 16'd4;
        push_expected(12);
        run_drain(1'b1, 1'b0, 1'b1, 1'b0, 3, 300);
        check("t2_bram_reads", bram_cnt, 12);
        check("t2_last_addr", last_addr, 32'h2C);
        check("t2_occupancy_viol", viol_cnt, 0);
        check("t2_clear_pulses", clear_cnt, 1);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_queue_left", exp_q.size(), 0);

        // zero entries: straight to clear
        reset_counters();
        num_entries = 16'd0;
        run_drain(1'b1, 1'b0, 1'b0, 1'b0, 3, 100);
        check("t3_bram_reads", bram_cnt, 0);
        check("t3_clear_lat", clear_cyc - start_cyc, 1);
        check("t3_clear_pulses", clear_cnt, 1);
        check("t3_done_pulses", done_cnt, 1);

        // auto drain on full rising edge, request clamped to log depth
        reset_counters();
        auto_drain = 1'b1;
        num_entries = 16'd20000;
        push_expected(49152);
        run_drain(1'b0, 1'b1, 1'b0, 1'b0, 3, 60000);
        check("t4_bram_reads", bram_cnt, 49152);
        check("t4_last_addr", last_addr, 32'h2FFFC);
        check("t4_occupancy_viol", viol_cnt, 0);
        check("t4_done_pulses", done_cnt, 1);
        check("t4_queue_left", exp_q.size(), 0);

        // start coincident with full edge, extra starts while busy
        reset_counters();
        num_entries = 16'd3;
        push_expected(9);
        run_drain(1'b1, 1'b1, 1'b0, 1'b1, 3, 200);
        check("t5_bram_reads", bram_cnt, 9);
        check("t5_clear_pulses", clear_cnt, 1);
        check("t5_done_pulses", done_cnt, 1);
        check("t5_queue_left", exp_q.size(), 0);

        // asynchronous reset in the middle of a drain
        reset_counters();
        auto_drain = 1'b0;
        num_entries = 16'd4;
        push_expected(12);
        n = 0;
        while (accepted < 3 && n < 50) begin
            @(posedge clk); #1;
            start = (n == 0);
            out_ready = 1'b1;
            n++;
        end
        start = 1'b0;
        check("t6_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("t6_mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        reset_counters();
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_clear", clear_cnt, 0);
        check("t6_no_done", done_cnt, 0);

        // fresh drain after reset starts at address 0
        reset_counters();
        num_entries = 16'd1;
        push_expected(3);
        run_drain(1'b1, 1'b0, 1'b0, 1'b0, 3, 100);
        check("t7_first_addr", first_addr, 32'h0);
        check("t7_last_addr", last_addr, 32'h8);
        check("t7_bram_reads", bram_cnt, 3);
        check("t7_done_pulses", done_cnt, 1);
        check("t7_queue_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
